// File: rtl/bcd_entry_monitor_if.sv
// Bundles the switch inputs and display/reading outputs of the BCD entry monitor.
interface bcd_entry_monitor_if #(
    parameter int NUM_DIGITS = 3
);
    logic [3:0]                  digit_in;
    logic                        enter;
    logic                        sign_in;
    logic [4*NUM_DIGITS-1:0]     disp_digits;
    logic                        disp_neg;
    logic                        blink;
    logic [4*NUM_DIGITS-1:0]     curr_value;
    logic                        curr_neg;
    logic [4*(NUM_DIGITS+1)-1:0] diff_mag;
    logic                        diff_neg;
    logic                        value_valid;
    logic                        alarm;

    // Driver side: switches and strobe out, display and readings in.
    modport master (
        output digit_in, enter, sign_in,
        input  disp_digits, disp_neg, blink, curr_value, curr_neg,
        input  diff_mag, diff_neg, value_valid, alarm
    );

    // Monitor side.
    modport slave (
        input  digit_in, enter, sign_in,
        output disp_digits, disp_neg, blink, curr_value, curr_neg,
        output diff_mag, diff_neg, value_valid, alarm
    );
endinterface

// File: rtl/bcd_entry_monitor.sv
// Digit-by-digit BCD reading entry with blinking cursor, signed difference against the
// previous reading and a threshold alarm on the difference magnitude.
module bcd_entry_monitor #(
    parameter int NUM_DIGITS  = 3,
    parameter int BLINK_DIV   = 25000000,
    parameter int ALARM_LIMIT = 10
) (
    input logic              clk,
    input logic              rst,
    bcd_entry_monitor_if.slave bus
);

    localparam int IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CntW  = $clog2(BLINK_DIV);
    localparam int MagW  = 4 * NUM_DIGITS;
    localparam int DiffW = 4 * (NUM_DIGITS + 1);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(BLINK_DIV - 1);

    typedef enum logic {StEntry, StShow} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [MagW-1:0]   cap_q, cap_d;
    logic [MagW-1:0]   curr_q, curr_d;
    logic              curr_neg_q, curr_neg_d;
    logic [DiffW-1:0]  diff_mag_q, diff_mag_d;
    logic              diff_neg_q, diff_neg_d;
    logic              alarm_q, alarm_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic [CntW-1:0]   cnt_q;
    logic              blink_q;

    logic              digit_ok;
    int unsigned       new_bin, old_bin;
    int                new_s, old_s, diff_s, diff_abs;

    // Packed BCD magnitude to binary.
    function automatic int unsigned bcd_to_bin(input logic [MagW-1:0] v);
        int unsigned acc;
        acc = 0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc = acc * 10 + 32'(v[4*i +: 4]);
        end
        return acc;
    endfunction

    // Binary magnitude to packed BCD with one extra digit for the difference range.
    function automatic logic [DiffW-1:0] bin_to_bcd(input int unsigned b);
        logic [DiffW-1:0] r;
        int unsigned      t;
        r = '0;
        t = b;
        for (int i = 0; i <= NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    assign digit_ok = (bus.digit_in <= 4'd9);

    // Free-running blink phase: toggles every BLINK_DIV cycles, starts lit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b1;
        end else if (cnt_q == CntMax) begin
            cnt_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // Entry FSM and committed-reading registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEntry;
            idx_q      <= '0;
            cap_q      <= '0;
            curr_q     <= '0;
            curr_neg_q <= 1'b0;
            diff_mag_q <= '0;
            diff_neg_q <= 1'b0;
            alarm_q    <= 1'b0;
            valid_q    <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cap_q      <= cap_d;
            curr_q     <= curr_d;
            curr_neg_q <= curr_neg_d;
            diff_mag_q <= diff_mag_d;
            diff_neg_q <= diff_neg_d;
            alarm_q    <= alarm_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
        end
    end

    // Next state: digit capture, commit with signed difference, and SHOW -> ENTRY restart.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_d      = cap_q;
        curr_d     = curr_q;
        curr_neg_d = curr_neg_q;
        diff_mag_d = diff_mag_q;
        diff_neg_d = diff_neg_q;
        alarm_d    = alarm_q;
        valid_d    = 1'b0;
        first_d    = first_q;
        new_bin    = 0;
        old_bin    = 0;
        new_s      = 0;
        old_s      = 0;
        diff_s     = 0;
        diff_abs   = 0;

        unique case (state_q)
            StEntry: begin
                if (bus.enter && digit_ok) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (IdxW'(i) == idx_q) begin
                            cap_d[4*i +: 4] = bus.digit_in;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        // The current reading becomes the previous operand of the difference.
                        new_bin  = bcd_to_bin(cap_d);
                        old_bin  = bcd_to_bin(curr_q);
                        new_s    = (bus.sign_in && new_bin != 0) ? -int'(new_bin) : int'(new_bin);
                        old_s    = curr_neg_q ? -int'(old_bin) : int'(old_bin);
                        diff_s   = new_s - old_s;
                        diff_abs = (diff_s < 0) ? -diff_s : diff_s;

                        curr_d     = cap_d;
                        curr_neg_d = bus.sign_in && (new_bin != 0);
                        diff_mag_d = bin_to_bcd($unsigned(diff_abs));
                        diff_neg_d = (diff_s < 0);
                        alarm_d    = first_q ? 1'b0 : (diff_abs > ALARM_LIMIT);
                        first_d    = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = StShow;
                        idx_d      = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StShow: begin
                if (bus.enter) begin
                    state_d = StEntry;
                    idx_d   = '0;
                    cap_d   = '0;
                end
            end
            default: state_d = StEntry;
        endcase
    end

    // Display: blinking cursor digit during entry, steady committed reading in SHOW.
    always_comb begin
        bus.disp_digits = '1;
        bus.disp_neg    = (state_q == StShow) ? curr_neg_q : bus.sign_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_q == StShow) begin
                bus.disp_digits[4*i +: 4] = curr_q[4*i +: 4];
            end else if (IdxW'(i) < idx_q) begin
                bus.disp_digits[4*i +: 4] = cap_q[4*i +: 4];
            end else if (IdxW'(i) == idx_q) begin
                bus.disp_digits[4*i +: 4] = blink_q ? bus.digit_in : 4'hF;
            end else begin
                bus.disp_digits[4*i +: 4] = 4'hF;
            end
        end
    end

    assign bus.blink       = blink_q;
    assign bus.curr_value  = curr_q;
    assign bus.curr_neg    = curr_neg_q;
    assign bus.diff_mag    = diff_mag_q;
    assign bus.diff_neg    = diff_neg_q;
    assign bus.value_valid = valid_q;
    assign bus.alarm       = alarm_q;

endmodule

// File: doc/bcd_entry_monitor.md
BCD_ENTRY_MONITOR -- requirements
Module: bcd_entry_monitor

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3: number of BCD magnitude digits entered, range 1-6.
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period, minimum 2.
REQ-003 SHALL have parameter ALARM_LIMIT, default 10: integer threshold on difference magnitude.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port digit_in  in  4  BCD digit from switches.
REQ-007 SHALL have port enter  in  1  single-cycle, pre-debounced, edge-detected capture strobe.
REQ-008 SHALL have port sign_in  in  1  sign of reading being entered, 1 = negative.
REQ-009 SHALL have port disp_digits  out  4*NUM_DIGITS  display codes; digit i at [4i+3:4i]; 4'hF = blank.
REQ-010 SHALL have port disp_neg  out  1  sign indicator for display.
REQ-011 SHALL have port blink  out  1  blink phase.
REQ-012 SHALL have port curr_value  out  4*NUM_DIGITS  last committed BCD magnitude.
REQ-013 SHALL have port curr_neg  out  1  last committed sign.
REQ-014 SHALL have port diff_mag  out  4*(NUM_DIGITS+1)  BCD magnitude of curr minus prev.
REQ-015 SHALL have port diff_neg  out  1  sign of difference.
REQ-016 SHALL have port value_valid  out  1  one-cycle pulse when curr/diff/alarm update.
REQ-017 SHALL have port alarm  out  1  level, |diff| > ALARM_LIMIT.

Function
REQ-018 SHALL run blink counter 0..BLINK_DIV-1; at wrap, blink toggles and counter returns to 0.
REQ-019 SHALL implement FSM states ENTRY (digit index idx 0..NUM_DIGITS-1, ones first) and SHOW.
REQ-020 SHALL, in ENTRY, ignore enter when digit_in > 9; no state, idx or capture change.
REQ-021 SHALL, in ENTRY with valid enter, capture digit_in at position idx; idx increments, except at idx = NUM_DIGITS-1.
REQ-022 SHALL, on valid enter at idx = NUM_DIGITS-1, sample sign_in, commit, and go to SHOW with idx = 0.
REQ-023 SHALL, at commit, move old curr to prev and load captured digits/sign into curr.
REQ-024 SHALL, in the cycle after commit's enter, pulse value_valid for one cycle with updated curr_value, curr_neg, diff_mag, diff_neg and alarm.
REQ-025 SHALL normalise all-zero magnitude to positive for curr_neg and diff_neg (no negative zero).
REQ-026 SHALL compute the signed difference exactly, e.g. -999 - 999 = -1998; no overflow, NUM_DIGITS+1 digits.
REQ-027 SHALL force alarm to 0 on the first commit after reset; it holds its level until the next commit.
REQ-028 SHALL, in SHOW, start ENTRY at idx 0 on enter; no digit is captured, and captured digits clear to 0.
REQ-029 SHALL, in ENTRY, display digit idx as digit_in when blink = 1, else 4'hF.
REQ-030 SHALL, in ENTRY, display digits below idx as captured values and digits above idx as 4'hF.
REQ-031 SHALL set disp_neg = sign_in in ENTRY and curr_neg in SHOW.
REQ-032 SHALL, in SHOW, display curr_value steadily (no blink).
REQ-033 SHALL keep all outputs registered except disp_digits and disp_neg, which may be combinational.

Reset
REQ-034 SHALL give rst priority over enter in the same cycle.
REQ-035 SHALL, on rst, set: state ENTRY, idx 0, captured/curr/prev 0, signs 0, diff 0, alarm 0, value_valid 0, blink 1, counter 0, first-commit flag set.
REQ-036 SHALL have rst mid-entry discard partial digits, with no value_valid pulse.

Verification (NUM_DIGITS=3, BLINK_DIV=4, ALARM_LIMIT=10)
REQ-037 SHALL test reset: after rst, expect blink=1, disp_digits={F,F,digit_in}, alarm=0, curr_value=000, value_valid=0.
REQ-038 SHALL test first reading: enter 5,2,1 with sign_in=0 -> next cycle value_valid=1, curr=125, diff=+0125, alarm=0.
REQ-039 SHALL test small change: enter in SHOW, then enter 0,2,1 -> curr=120, diff_mag=0005, diff_neg=1, alarm=0.
REQ-040 SHALL test alarm: enter in SHOW, then 0,0,1 with sign_in=1 -> curr=-100, diff_mag=0220, diff_neg=1, alarm=1.
REQ-041 SHALL test invalid digit and blink: digit_in=4'hA with enter -> idx unchanged; active digit toggles with 4'hF every 4 cycles.
REQ-042 SHALL test reset mid-entry: rst after two digits -> idx=0, curr=000, alarm=0, no value_valid.
